dmem_responder: RTL

Data-memory responder for the single-cycle RISC-V core's load/store path. It accepts one request at a time from the core's memory initiator over a valid/ready request channel and returns read data or a completion over a valid/ready response channel. It contains a byte-strobed word RAM, applies a configurable number of wait states, and flags misaligned, oversized and out-of-range accesses. The core performs load sign extension; this block returns zero-extended lanes.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_ram.sv | 28 ++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Size codes, FSM states, strobe and alignment decode.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [3:0] byte_strobe(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (size)
      SIZE_B:  s = 4'b0001 << lo;
      SIZE_H:  s = 4'b0011 << lo;
      SIZE_W:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return ((size == SIZE_H) && lo[0]) ||
           ((size == SIZE_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with per-byte write strobes and a registered read port.
// Read and write share one address; reads return pre-write data.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    strb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: request latch, wait states, fault decode,
// byte-lane steering around a strobed word RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t state, state_nx;
  logic [3:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr;
  logic [1:0]  l_size;
  logic [31:0] l_wdata;

  logic        accept, hs, enter_resp, in_idle;
  logic        cmd_we;
  logic [31:0] cmd_addr, cmd_wdata, off;
  logic [1:0]  cmd_size;
  logic        err;
  logic        ram_we;
  logic [3:0]  ram_strb;
  logic [31:0] ram_wdata, ram_q;
  logic [31:0] shifted, load_data;

  assign in_idle    = (state == IDLE);
  assign req_ready  = in_idle && !rst;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign hs         = resp_valid && resp_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt == 4'd0) state_nx = RESP;
      RESP: if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_nx == RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_we    <= 1'b0;
      l_addr  <= 32'd0;
      l_size  <= SIZE_B;
      l_wdata <= 32'd0;
    end else if (accept) begin
      l_we    <= req_we;
      l_addr  <= req_addr;
      l_size  <= req_size;
      l_wdata <= req_wdata;
    end
  end

  // Live request in IDLE so a zero-wait access and the RAM read
  // issued on the acceptance edge both see the incoming command.
  assign cmd_we    = in_idle ? req_we    : l_we;
  assign cmd_addr  = in_idle ? req_addr  : l_addr;
  assign cmd_size  = in_idle ? req_size  : l_size;
  assign cmd_wdata = in_idle ? req_wdata : l_wdata;

  assign off = cmd_addr - BASE_ADDR;
  assign err = (cmd_size == SIZE_X) ||
               misaligned(cmd_size, off[1:0]) ||
               (off >= SPAN);

  always_comb begin
    ram_wdata = cmd_wdata;
    unique case (cmd_size)
      SIZE_B:  ram_wdata = {4{cmd_wdata[7:0]}};
      SIZE_H:  ram_wdata = {2{cmd_wdata[15:0]}};
      default: ram_wdata = cmd_wdata;
    endcase
  end

  assign ram_strb = byte_strobe(cmd_size, off[1:0]);
  assign ram_we   = enter_resp && cmd_we && !err && !rst;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .strb (ram_strb),
    .addr (off[AW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  assign shifted = ram_q >> {l_addr[1:0], 3'b000};

  always_comb begin
    load_data = shifted;
    unique case (1'b1)
      (l_size == SIZE_B): load_data = {24'd0, shifted[7:0]};
      (l_size == SIZE_H): load_data = {16'd0, shifted[15:0]};
      default:            load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if (enter_resp) begin
      resp_err <= err;
    end else if (hs) begin
      resp_err <= 1'b0;
    end
  end

  // RAM output is held by the latched index for the whole response.
  assign resp_rdata = (resp_valid && !l_we && !resp_err)
                    ? load_data : 32'd0;

endmodule
